phasor_sample_fifo: RTL and testbench

- Downstream consumer of the two phasor generators.
- Sums the two signed 20-bit phasor outputs at a fixed sample rate, saturates the sum, and buffers it in a FIFO.
- The HPS drains the FIFO over PIO using a 4-phase request/acknowledge handshake, so no samples are lost between HPS polls.
- Sits between the phasor instances and the PIO read ports in the top level.

---
 rtl/phasor_sample_fifo.sv | 160 ++++++++++++++++
 tb/tb_phasor_sample_fifo.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phasor_sample_fifo.sv
// Sums two signed phasor outputs at a fixed sample rate, saturates to 20 bits,
// and buffers samples for the HPS, which reads them with a 4-phase req/ack handshake.
module phasor_sample_fifo #(
   parameter int SAMPLE_DIV = 1000,
   parameter int DEPTH      = 16,
   parameter int AW         = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic [19:0]   in0,
   input  logic [19:0]   in1,
   input  logic          rd_req,
   input  logic          clear_ovf,
   output logic [19:0]   rd_data,
   output logic          rd_ack,
   output logic [AW:0]   count,
   output logic          empty,
   output logic          full,
   output logic          overflow,
   output logic [15:0]   drop_count
);

   localparam int              DW       = $clog2(SAMPLE_DIV);
   localparam logic [DW-1:0]   DIV_LAST = DW'(SAMPLE_DIV - 1);
   localparam logic [AW:0]     DEPTH_C  = (AW+1)'(DEPTH);

   typedef enum logic {IDLE, ACK} state_t;

   logic [DW-1:0] div;
   logic          tick;
   logic [20:0]   s1;
   logic          s1_valid;
   logic [19:0]   sat;
   logic          push_ok;
   logic          drop;
   logic          pop;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [19:0]   mem [DEPTH];
   logic          req_m;
   logic          req_s;
   state_t        state;
   state_t        state_nxt;

   assign tick = en && (div == DIV_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         div <= '0;
      else if (!en || tick)
         div <= '0;
      else
         div <= div + DW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1       <= '0;
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= tick;
         if (tick)
            s1 <= {in0[19], in0} + {in1[19], in1};
      end
   end

   // The 21-bit sum overflowed 20 bits exactly when its top two bits disagree.
   always_comb begin
      sat = s1[19:0];
      if (s1[20] != s1[19])
         sat = s1[20] ? 20'h80000 : 20'h7FFFF;
   end

   assign empty   = (count == '0);
   assign full    = (count == DEPTH_C);
   assign push_ok = s1_valid && !full;
   assign drop    = s1_valid && full;

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= sat;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr  <= rd_ptr + AW'(1);
            rd_data <= mem[rd_ptr];
         end
         case ({push_ok, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // A drop in the same cycle as clear_ovf restarts the tally at one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (clear_ovf)
            drop_count <= 16'd1;
         else if (drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
      end else if (clear_ovf) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_m <= 1'b0;
         req_s <= 1'b0;
      end else begin
         req_m <= rd_req;
         req_s <= req_m;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (req_s && !empty) begin
               pop       = 1'b1;
               state_nxt = ACK;
            end
         end
         ACK: begin
            if (!req_s)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rd_ack = (state == ACK);

endmodule

// File: tb/tb_phasor_sample_fifo.sv
// Self-checking bench for phasor_sample_fifo: vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_phasor_sample_fifo;

   localparam int SAMPLE_DIV = 4;
   localparam int DEPTH      = 16;
   localparam int AW         = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          en;
   logic [19:0]   in0;
   logic [19:0]   in1;
   logic          rd_req;
   logic          clear_ovf;
   logic [19:0]   rd_data;
   logic          rd_ack;
   logic [AW:0]   count;
   logic          empty;
   logic          full;
   logic          overflow;
   logic [15:0]   drop_count;

   int tests = 0;
   int fails = 0;

   phasor_sample_fifo #(
      .SAMPLE_DIV (SAMPLE_DIV),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .in0        (in0),
      .in1        (in1),
      .rd_req     (rd_req),
      .clear_ovf  (clear_ovf),
      .rd_data    (rd_data),
      .rd_ack     (rd_ack),
      .count      (count),
      .empty      (empty),
      .full       (full),
      .overflow   (overflow),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [19:0] a;
      logic [19:0] b;
      logic [19:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset     = 1'b0;
      en        = 1'b0;
      rd_req    = 1'b0;
      clear_ovf = 1'b0;
      in0       = '0;
      in1       = '0;
      step(3);
      reset = 1'b1;
      step(1);
   endtask

   // en is raised for exactly one tick period, so the inputs are captured once.
   task automatic one_sample(input logic [19:0] a, input logic [19:0] b);
      en  = 1'b1;
      in0 = a;
      in1 = b;
      step(SAMPLE_DIV);
      en = 1'b0;
      step(2);
   endtask

   task automatic do_read(input string name, output logic [19:0] d);
      int n;
      rd_req = 1'b1;
      n = 0;
      while (!rd_ack && n < 20) begin
         step(1);
         n++;
      end
      check({name, "_ack_rise"}, rd_ack, 1'b1);
      d = rd_data;
      rd_req = 1'b0;
      n = 0;
      while (rd_ack && n < 20) begin
         step(1);
         n++;
      end
      check({name, "_ack_fall"}, rd_ack, 1'b0);
   endtask

   function automatic logic [19:0] ref_sum(input logic [19:0] a, input logic [19:0] b);
      int sa;
      int sb;
      int s;
      logic [31:0] r;
      sa = $signed(a);
      sb = $signed(b);
      s  = sa + sb;
      if (s > 524287)  s = 524287;
      if (s < -524288) s = -524288;
      r = s;
      return r[19:0];
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t        vecs[8];
      logic [19:0] d;
      logic [19:0] mq[$];
      int          drops;
      int          n;

      vecs[0] = '{"basic",     20'h00010, 20'h00005, 20'h00015};
      vecs[1] = '{"sat_pos",   20'h7FFFF, 20'h7FFFF, 20'h7FFFF};
      vecs[2] = '{"sat_neg",   20'h80000, 20'h80000, 20'h80000};
      vecs[3] = '{"max_m1",    20'h7FFFF, 20'hFFFFF, 20'h7FFFE};
      vecs[4] = '{"m1_p1",     20'hFFFFF, 20'h00001, 20'h00000};
      vecs[5] = '{"max_p1",    20'h7FFFF, 20'h00001, 20'h7FFFF};
      vecs[6] = '{"min_m1",    20'h80000, 20'hFFFFF, 20'h80000};
      vecs[7] = '{"plain",     20'h12345, 20'h00000, 20'h12345};

      // Reset values while reset is held low
      reset = 1'b0; en = 1'b0; rd_req = 1'b0; clear_ovf = 1'b0; in0 = '0; in1 = '0;
      step(2);
      check("rst_rd_data", rd_data, 20'h0);
      check("rst_rd_ack", rd_ack, 1'b0);
      check("rst_count", count, 5'd0);
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_drop_count", drop_count, 16'h0);
      reset = 1'b1;
      step(1);

      // Vector table: one sample, then one read
      foreach (vecs[i]) begin
         one_sample(vecs[i].a, vecs[i].b);
         check({vecs[i].name, "_count"}, count, 5'd1);
         do_read(vecs[i].name, d);
         check({vecs[i].name, "_data"}, d, vecs[i].exp);
         check({vecs[i].name, "_count_after"}, count, 5'd0);
      end

      // Continuous enable: a sample lands every SAMPLE_DIV cycles
      apply_reset();
      en = 1'b1; in0 = 20'h00010; in1 = 20'h00005;
      step(4);  check("tick_cnt_e4", count, 5'd0);
      step(1);  check("tick_cnt_e5", count, 5'd1);
      step(3);  check("tick_cnt_e8", count, 5'd1);
      step(1);  check("tick_cnt_e9", count, 5'd2);
      step(4);  check("tick_cnt_e13", count, 5'd3);
      en = 1'b0;
      step(4);  check("tick_cnt_hold", count, 5'd3);
      for (int i = 0; i < 3; i++) begin
         do_read("tick_rd", d);
         check("tick_data", d, 20'h00015);
      end
      check("tick_empty", empty, 1'b1);

      // Fill past full, drain in order, then clear the overflow state
      apply_reset();
      for (int i = 0; i < DEPTH + 3; i++)
         one_sample(20'(i), 20'h0);
      check("fill_full", full, 1'b1);
      check("fill_count", count, 5'd16);
      check("fill_overflow", overflow, 1'b1);
      check("fill_drops", drop_count, 16'd3);
      for (int i = 0; i < DEPTH; i++) begin
         do_read("drain", d);
         check("drain_data", d, 20'(i));
      end
      check("drain_empty", empty, 1'b1);
      clear_ovf = 1'b1; step(1); clear_ovf = 1'b0;
      check("clr_overflow", overflow, 1'b0);
      check("clr_drops", drop_count, 16'd0);

      // Full FIFO: a pop on the same edge as the push still drops the push
      apply_reset();
      for (int i = 0; i < DEPTH; i++)
         one_sample(20'(i), 20'h0);
      en = 1'b1; in0 = 20'h00099; in1 = 20'h0;
      step(2);
      rd_req = 1'b1;
      step(2);
      en = 1'b0;
      step(1);
      check("coin_count", count, 5'd15);
      check("coin_drops", drop_count, 16'd1);
      check("coin_overflow", overflow, 1'b1);
      check("coin_ack", rd_ack, 1'b1);
      check("coin_data", rd_data, 20'h0);
      rd_req = 1'b0;
      step(3);
      check("coin_ack_fall", rd_ack, 1'b0);
      for (int i = 1; i < DEPTH; i++) begin
         do_read("coin_drain", d);
         check("coin_drain_data", d, 20'(i));
      end

      // Reset in the middle of an acknowledged read with 5 samples buffered
      apply_reset();
      for (int i = 0; i < 5; i++)
         one_sample(20'(i + 1), 20'h0);
      rd_req = 1'b1;
      n = 0;
      while (!rd_ack && n < 20) begin step(1); n++; end
      check("rmid_ack_before", rd_ack, 1'b1);
      reset = 1'b0;
      #1;
      check("rmid_ack", rd_ack, 1'b0);
      check("rmid_count", count, 5'd0);
      check("rmid_empty", empty, 1'b1);
      check("rmid_data", rd_data, 20'h0);
      rd_req = 1'b0;
      step(1);
      reset = 1'b1;
      step(1);
      one_sample(20'h00003, 20'h00004);
      check("rmid_after_count", count, 5'd1);
      do_read("rmid_after", d);
      check("rmid_after_data", d, 20'h00007);

      // Request while empty, then a sample arrives with the request still high
      apply_reset();
      rd_req = 1'b1;
      step(6);
      check("emp_no_ack", rd_ack, 1'b0);
      en = 1'b1; in0 = 20'h00021; in1 = 20'h00001;
      step(4);
      en = 1'b0;
      step(1);
      check("emp_write_count", count, 5'd1);
      check("emp_write_noack", rd_ack, 1'b0);
      step(1);
      check("emp_ack", rd_ack, 1'b1);
      check("emp_pop_count", count, 5'd0);
      check("emp_data", rd_data, 20'h00022);
      one_sample(20'h00030, 20'h0);
      check("emp_one_pop", count, 5'd1);
      check("emp_ack_held", rd_ack, 1'b1);
      check("emp_data_held", rd_data, 20'h00022);
      rd_req = 1'b0;
      step(2);
      check("emp_ack_2cyc", rd_ack, 1'b1);
      step(1);
      check("emp_ack_3cyc", rd_ack, 1'b0);
      do_read("emp_second", d);
      check("emp_second_data", d, 20'h00030);

      // Randomized bursts against a queue model
      for (int r = 0; r < 4; r++) begin
         logic [19:0] a;
         logic [19:0] b;
         apply_reset();
         mq.delete();
         drops = 0;
         n = $urandom_range(1, 22);
         for (int i = 0; i < n; i++) begin
            a = 20'($urandom);
            b = 20'($urandom);
            if (($urandom & 3) == 0) a = ($urandom & 1) ? 20'h7FFFF : 20'h80000;
            one_sample(a, b);
            if (mq.size() < DEPTH) mq.push_back(ref_sum(a, b));
            else drops++;
         end
         check("rnd_count", count, 32'(mq.size()));
         check("rnd_full", full, (mq.size() == DEPTH));
         check("rnd_overflow", overflow, (drops > 0));
         check("rnd_drops", drop_count, 32'(drops));
         while (mq.size() > 0) begin
            do_read("rnd_rd", d);
            check("rnd_data", d, mq.pop_front());
         end
         check("rnd_empty", empty, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
